seven_segment_scan_driver: RTL and testbench

- Time-multiplexed driver for a common-anode, multi-digit 7-segment display: one digit enabled at a time, each digit decoded from a 4-bit hex/BCD nibble.
- Adds what a bare decoder lacks: digit scanning, double-buffered frame load, leading-zero suppression, per-digit blanking and decimal point, PWM brightness and an anti-ghosting guard.
- Sits between the clock/time-keeping logic and the board display pins.

---
 rtl/seven_segment_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_driver
// Purpose  : Time-multiplexed driver for a common-anode multi-digit 7-segment
//            display. Scans one digit per slot, decodes hex nibbles, buffers
//            a full frame so updates never tear, suppresses leading zeros,
//            supports per-digit blanking / decimal point, PWM brightness and
//            an all-anodes-off guard at the start of every slot.
// Ports    : clk          - system clock
//            reset        - synchronous active-high reset
//            digits_in    - 4*NUM_DIGITS nibbles, digit 0 in [3:0] (rightmost)
//            dp_in        - per-digit decimal point request (1 = lit)
//            blank_in     - per-digit forced blank (1 = segments off)
//            lz_suppress  - 1 = blank leading zeros
//            load         - 1-cycle strobe capturing digits/dp/blank
//            brightness   - 0 = dark, all-ones = full on
//            seg_n        - active-low segments, bit0 = a ... bit6 = g
//            dp_n         - active-low decimal point
//            an_n         - active-low anode enables (at most one low)
//            frame_tick   - 1-cycle pulse after the scan wraps to digit 0
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int GUARD       = 16,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic                    load,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_GRD  = PRESC_W'(GUARD);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Scan / PWM state
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BRIGHT_BITS-1:0]  pwm_q;

    // Hold (written by load) and display (copied at frame wrap) registers
    logic [4*NUM_DIGITS-1:0] hold_dig_q, disp_dig_q;
    logic [NUM_DIGITS-1:0]   hold_dp_q, disp_dp_q;
    logic [NUM_DIGITS-1:0]   hold_blank_q, disp_blank_q;

    // Registered outputs
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_tick_q;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [3:0]              w_nibs [NUM_DIGITS];
    logic [NUM_DIGITS:0]     w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_seg_blank;
    logic [3:0]              w_sel_nib;
    logic                    w_sel_blank;
    logic                    w_sel_dp;
    logic                    w_gate;
    logic                    w_an_on;
    logic [NUM_DIGITS-1:0]   w_onehot;

    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // w_upper_zero[i] is set when every displayed nibble from the most
    // significant digit down to digit i is zero.
    assign w_upper_zero[NUM_DIGITS] = 1'b1;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_nibs[i]       = disp_dig_q[4*i +: 4];
            assign w_upper_zero[i] = w_upper_zero[i+1] && (w_nibs[i] == 4'h0);
            if (i == 0) begin : g_lsd
                // The rightmost digit always shows, so a zero value reads "0".
                assign w_seg_blank[i] = disp_blank_q[i];
            end else begin : g_upper
                assign w_seg_blank[i] = disp_blank_q[i] |
                                        (lz_suppress & w_upper_zero[i]);
            end
        end
    endgenerate

    always_comb begin
        w_slot_end = (presc_q == PRESC_LAST);
        w_wrap     = w_slot_end && (idx_q == IDX_LAST);

        presc_d = w_slot_end ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (w_slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        w_sel_nib   = w_nibs[idx_q];
        w_sel_blank = w_seg_blank[idx_q];
        w_sel_dp    = disp_dp_q[idx_q];

        w_gate  = (&brightness) || (pwm_q < brightness);
        // A digit with blanked segments but a lit dp still needs its anode.
        w_an_on = (presc_q >= PRESC_GRD) && w_gate && !(w_sel_blank && !w_sel_dp);

        w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
        an_n_d   = w_an_on ? ~w_onehot : '1;
        seg_n_d  = w_sel_blank ? 7'h7F : hex_to_seg_n(w_sel_nib);
        dp_n_d   = ~w_sel_dp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            hold_dig_q   <= '0;
            hold_dp_q    <= '0;
            hold_blank_q <= '0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_q + 1'b1;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= w_wrap;
            if (load) begin
                hold_dig_q   <= digits_in;
                hold_dp_q    <= dp_in;
                hold_blank_q <= blank_in;
            end
            // Old hold contents move to the display on the wrap edge, so a
            // load landing on that same edge waits one more frame.
            if (w_wrap) begin
                disp_dig_q   <= hold_dig_q;
                disp_dp_q    <= hold_dp_q;
                disp_blank_q <= hold_blank_q;
            end
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scan_driver
// Purpose  : Directed self-checking bench for seven_segment_scan_driver with
//            NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, BRIGHT_BITS=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_suppress;
    logic        load;
    logic [1:0]  brightness;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;
    int t     = 0;   // edges since reset release; output after edge t reflects state t-1

    always #5 clk = ~clk;

    seven_segment_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .GUARD      (2),
        .BRIGHT_BITS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_suppress(lz_suppress),
        .load       (load),
        .brightness (brightness),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        blank_in  = 4'b0000;
        step();
        reset = 1'b0;
        t     = 0;
    endtask

    // Expected anode vector for scan state s: lit only after the 2-cycle guard.
    function automatic logic [3:0] an_exp(input int s, input logic open, input logic dark);
        logic [3:0] one;
        one = 4'b0001;
        if ((s % 8) >= 2 && open && !dark) return ~(one << ((s / 8) % 4));
        return 4'hF;
    endfunction

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; digits_in = 16'h8888; dp_in = 4'hF;
        blank_in = 4'h0; lz_suppress = 1'b0; brightness = 2'd3;
        repeat (3) step();
        tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h exp 7f", seg_n); end
        tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp got %b exp 1", dp_n); end
        tests++; if (an_n !== 4'hF) begin fails++; $display("FAIL reset_an got %b exp 1111", an_n); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
    endtask

    task automatic test_blank_start();
        int s, idx, ticks;
        logic [6:0] es;
        do_reset();
        lz_suppress = 1'b0; brightness = 2'd3; ticks = 0;
        repeat (64) begin
            step(); s = t - 1;
            tests++; if (an_n !== an_exp(s, 1'b1, 1'b0)) begin fails++; $display("FAIL blank_an t=%0d got %b exp %b", t, an_n, an_exp(s, 1'b1, 1'b0)); end
            tests++; if (seg_n !== 7'h40) begin fails++; $display("FAIL blank_seg t=%0d got %h exp 40", t, seg_n); end
            tests++; if (frame_tick !== ((s % 32) == 31)) begin fails++; $display("FAIL blank_tick t=%0d got %b", t, frame_tick); end
            if (frame_tick === 1'b1) ticks++;
        end
        tests++; if (ticks != 2) begin fails++; $display("FAIL tick_count got %0d exp 2", ticks); end
        lz_suppress = 1'b1;
        repeat (32) begin
            step(); s = t - 1; idx = (s / 8) % 4;
            es = (idx == 0) ? 7'h40 : 7'h7F;
            tests++; if (seg_n !== es) begin fails++; $display("FAIL lz0_seg t=%0d got %h exp %h", t, seg_n, es); end
            tests++; if (an_n !== an_exp(s, 1'b1, idx != 0)) begin fails++; $display("FAIL lz0_an t=%0d got %b exp %b", t, an_n, an_exp(s, 1'b1, idx != 0)); end
        end
    endtask

    task automatic test_load_buffer();
        int s, idx;
        logic [6:0] tbl [4];
        logic [6:0] es;
        tbl[0] = 7'h12; tbl[1] = 7'h08; tbl[2] = 7'h24; tbl[3] = 7'h79;
        do_reset();
        lz_suppress = 1'b0; brightness = 2'd3;
        while (t < 160) begin
            step(); s = t - 1; idx = (s / 8) % 4;
            if (s < 32)       es = 7'h40;      // load mid-frame: old frame finishes
            else if (s < 96)  es = tbl[idx];   // wrap-edge load not yet visible
            else if (s < 128) es = 7'h00;      // "8888"
            else              es = 7'h0E;      // last of two loads wins: "FFFF"
            tests++; if (seg_n !== es) begin fails++; $display("FAIL load_seg t=%0d got %h exp %h", t, seg_n, es); end
            tests++; if (an_n !== an_exp(s, 1'b1, 1'b0)) begin fails++; $display("FAIL load_an t=%0d got %b exp %b", t, an_n, an_exp(s, 1'b1, 1'b0)); end
            load = 1'b0;
            if (t == 10)  begin digits_in = 16'h12A5; load = 1'b1; end
            if (t == 63)  begin digits_in = 16'h8888; load = 1'b1; end
            if (t == 100) begin digits_in = 16'h1111; load = 1'b1; end
            if (t == 105) begin digits_in = 16'hFFFF; load = 1'b1; end
        end
        load = 1'b0;
    endtask

    task automatic test_lz_suppress();
        int s, idx;
        logic [6:0] es;
        logic       ed, ek;
        do_reset();
        lz_suppress = 1'b1; brightness = 2'd3;
        digits_in = 16'h0030; dp_in = 4'b0100; blank_in = 4'b0000; load = 1'b1;
        step(); load = 1'b0;
        while (t < 96) begin
            step(); s = t - 1; idx = (s / 8) % 4;
            ed = (idx == 2) ? 1'b0 : 1'b1;
            case (idx)
                0: begin es = 7'h40; ek = 1'b0; end
                1: begin es = (s < 64) ? 7'h30 : 7'h7F; ek = (s >= 64); end
                2: begin es = 7'h7F; ek = 1'b0; end
                default: begin es = 7'h7F; ek = 1'b1; end
            endcase
            if (s >= 32) begin
                tests++; if (seg_n !== es) begin fails++; $display("FAIL lz_seg t=%0d got %h exp %h", t, seg_n, es); end
                tests++; if (dp_n !== ed) begin fails++; $display("FAIL lz_dp t=%0d got %b exp %b", t, dp_n, ed); end
                tests++; if (an_n !== an_exp(s, 1'b1, ek)) begin fails++; $display("FAIL lz_an t=%0d got %b exp %b", t, an_n, an_exp(s, 1'b1, ek)); end
            end
            load = 1'b0;
            if (t == 40) begin blank_in = 4'b0010; load = 1'b1; end
        end
        load = 1'b0; blank_in = 4'b0000; dp_in = 4'b0000; lz_suppress = 1'b0;
    endtask

    task automatic test_brightness();
        int s;
        do_reset();
        lz_suppress = 1'b0; brightness = 2'd0;
        repeat (32) begin
            step();
            tests++; if (an_n !== 4'hF) begin fails++; $display("FAIL bright0_an t=%0d got %b exp 1111", t, an_n); end
        end
        brightness = 2'd1;
        repeat (32) begin
            step(); s = t - 1;
            tests++; if (an_n !== an_exp(s, (s % 4) == 0, 1'b0)) begin fails++; $display("FAIL bright1_an t=%0d got %b exp %b", t, an_n, an_exp(s, (s % 4) == 0, 1'b0)); end
        end
        brightness = 2'd2;
        repeat (32) begin
            step(); s = t - 1;
            tests++; if (an_n !== an_exp(s, (s % 4) < 2, 1'b0)) begin fails++; $display("FAIL bright2_an t=%0d got %b exp %b", t, an_n, an_exp(s, (s % 4) < 2, 1'b0)); end
        end
        brightness = 2'd3;
    endtask

    task automatic test_reset_mid();
        int s;
        do_reset();
        lz_suppress = 1'b0; brightness = 2'd3;
        digits_in = 16'h12A5; load = 1'b1;
        step(); load = 1'b0;
        while (t < 52) step();
        // state 51 = digit 2, post-guard: "2" lit on anode 2
        tests++; if (an_n !== 4'b1011) begin fails++; $display("FAIL mid_pre_an got %b exp 1011", an_n); end
        tests++; if (seg_n !== 7'h24) begin fails++; $display("FAIL mid_pre_seg got %h exp 24", seg_n); end
        reset = 1'b1;
        step();
        tests++; if (an_n !== 4'hF) begin fails++; $display("FAIL mid_an got %b exp 1111", an_n); end
        tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL mid_seg got %h exp 7f", seg_n); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL mid_tick got %b exp 0", frame_tick); end
        tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL mid_dp got %b exp 1", dp_n); end
        reset = 1'b0; t = 0;
        repeat (40) begin
            step(); s = t - 1;
            tests++; if (an_n !== an_exp(s, 1'b1, 1'b0)) begin fails++; $display("FAIL restart_an t=%0d got %b exp %b", t, an_n, an_exp(s, 1'b1, 1'b0)); end
            tests++; if (seg_n !== 7'h40) begin fails++; $display("FAIL restart_seg t=%0d got %h exp 40", t, seg_n); end
            tests++; if (frame_tick !== ((s % 32) == 31)) begin fails++; $display("FAIL restart_tick t=%0d got %b", t, frame_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_blank_start();
        test_load_buffer();
        test_lz_suppress();
        test_brightness();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
